flow_ctrl_unit: RTL

//  Consumer side of the ALU flag interface: captures zero/sign/carry/mode flags

---
 rtl/flow_ctrl_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/flow_ctrl_unit.sv
// -----------------------------------------------------------------------------
// flow_ctrl_unit
//   Consumer side of the ALU flag interface. Captures zero/sign/carry/mode into
//   a 4-bit status register, executes program-flow ops and owns the program
//   counter plus a two-state RUN/TRAP machine.
//
// Ports
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   op_valid/op_ready/op_code/op_target/op_imm   decoder issue channel
//   alu_zero/alu_sign/alu_carry/alu_mode         ALU flags, captured on FLAG
//   trap_ack      handler acknowledge, returns TRAP -> RUN
//   pc            current program counter
//   status        {mode, carry, sign, zero}
//   taken         one-cycle pulse: last accepted op redirected pc
//   trap          high while in TRAP
//   trap_cause    0 = explicit TRAP, 1 = illegal opcode (10..15)
//   fsm_state     debug view of the RUN/TRAP state (0 = RUN, 1 = TRAP)
//
// Handshake: an op transfers on a rising edge where op_valid & op_ready are
// both high. op_ready depends only on the state (high in RUN, low in TRAP),
// never on op_valid. While op_ready is low the decoder must hold its op; the
// unit ignores it completely. A transferred op takes effect at that edge.
// -----------------------------------------------------------------------------
module flow_ctrl_unit #(
  parameter int                 WORD_W   = 20,
  parameter logic [WORD_W-1:0]  RESET_PC = '0,
  parameter logic [WORD_W-1:0]  TRAP_VEC = 20'h00010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [WORD_W-1:0] op_target,
  input  logic [3:0]        op_imm,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_carry,
  input  logic              alu_mode,
  input  logic              trap_ack,
  output logic [WORD_W-1:0] pc,
  output logic [3:0]        status,
  output logic              taken,
  output logic              trap,
  output logic              trap_cause,
  output logic              fsm_state
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_TRAP = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_JZ   = 4'd3;
  localparam logic [3:0] OP_JS   = 4'd4;
  localparam logic [3:0] OP_JZS  = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
  localparam logic [3:0] OP_XSR  = 4'd7;
  localparam logic [3:0] OP_FLAG = 4'd8;
  localparam logic [3:0] OP_RET  = 4'd9;

  logic [0:0]        state, state_n;
  logic [WORD_W-1:0] pc_n, epc, epc_n, pc_seq;
  logic [3:0]        status_n;
  logic              taken_n, cause_n, xfer;

  assign op_ready  = (state == ST_RUN);
  assign trap      = (state == ST_TRAP);
  assign fsm_state = state[0];
  assign xfer      = op_valid & op_ready;
  // Natural WORD_W-bit overflow gives the required wrap to zero.
  assign pc_seq    = pc + 1'b1;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    epc_n    = epc;
    status_n = status;
    cause_n  = trap_cause;
    taken_n  = 1'b0;
    if (state == ST_TRAP) begin
      if (trap_ack) state_n = ST_RUN;
    end else if (xfer) begin
      case (op_code)
        OP_NOP:  pc_n = pc_seq;
        OP_JMP: begin
          pc_n    = op_target;
          taken_n = 1'b1;
        end
        // Conditions look at the status held before this op.
        OP_JZ, OP_JS, OP_JZS: begin
          if ((op_code != OP_JS  && status[0]) ||
              (op_code != OP_JZ  && status[1])) begin
            pc_n    = op_target;
            taken_n = 1'b1;
          end else begin
            pc_n = pc_seq;
          end
        end
        OP_LSR: begin
          status_n = op_imm;
          pc_n     = pc_seq;
        end
        OP_XSR: begin
          status_n = status ^ op_imm;
          pc_n     = pc_seq;
        end
        OP_FLAG: begin
          status_n = {alu_mode, alu_carry, alu_sign, alu_zero};
          pc_n     = pc_seq;
        end
        OP_RET: begin
          pc_n    = epc;
          taken_n = 1'b1;
        end
        default: begin
          // Explicit TRAP and the illegal opcodes 10..15 share trap entry.
          epc_n   = pc_seq;
          pc_n    = TRAP_VEC;
          state_n = ST_TRAP;
          taken_n = 1'b1;
          cause_n = (op_code != OP_TRAP);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      epc        <= '0;
      status     <= '0;
      taken      <= 1'b0;
      trap_cause <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      epc        <= epc_n;
      status     <= status_n;
      taken      <= taken_n;
      trap_cause <= cause_n;
    end
  end

endmodule
